// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor
// Error-statistics stage placed behind an unsigned 8x8 approximate multiplier.
// Each accepted sample (x, y, z_apx) is checked against the exact product and
// folded into the run statistics: error count, sum of absolute error, and the
// maximum absolute error together with the operands that first produced it.
// Optional feature macro: MON_SQERR_EN adds a registered squaring stage and the
// sum_sq_err output (sum of squared absolute errors).
module approx_mul_err_monitor #(
  parameter int CNT_W = 17,
  parameter int SUM_W = 16 + CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic [15:0]      z_apx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [15:0]      max_abs_err,
  output logic [7:0]       max_x,
`ifdef MON_SQERR_EN
  output logic [2*16+CNT_W-2:0] sum_sq_err,
`endif
  output logic [7:0]       max_y
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_nLat;
  logic [CNT_W-1:0] r_acceptCnt;

  logic             w_take;
  logic             w_startRun;
  logic             w_pipeBusy;
  logic             w_runDone;

  // Stage 1: captured operands and exact product
  logic             r_s1Valid;
  logic [7:0]       r_s1X;
  logic [7:0]       r_s1Y;
  logic [15:0]      r_s1Z;
  logic [15:0]      r_s1Exact;

  // Stage 2: absolute error
  logic             r_s2Valid;
  logic [7:0]       r_s2X;
  logic [7:0]       r_s2Y;
  logic [15:0]      r_s2Abs;

  logic [16:0]      w_diff;
  logic [15:0]      w_abs;

  // Signals presented to the accumulators by the last pipeline stage
  logic             w_finValid;
  logic [7:0]       w_finX;
  logic [7:0]       w_finY;
  logic [15:0]      w_finAbs;

  assign in_ready   = (r_state == ST_RUN) && (r_acceptCnt < r_nLat);
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign w_take     = in_valid && in_ready;
  assign w_startRun = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // 17-bit two's-complement difference; the sign bit selects negation and the
  // magnitude always fits in 16 bits because both operands are 16-bit unsigned.
  assign w_diff = {1'b0, r_s1Z} - {1'b0, r_s1Exact};
  assign w_abs  = w_diff[16] ? (~w_diff[15:0] + 16'd1) : w_diff[15:0];

`ifdef MON_SQERR_EN
  logic             r_s3Valid;
  logic [7:0]       r_s3X;
  logic [7:0]       r_s3Y;
  logic [15:0]      r_s3Abs;
  logic [31:0]      r_s3Sq;

  // The run may only finish once no sample is still travelling towards the accumulators
  assign w_pipeBusy = r_s1Valid || r_s2Valid;
  assign w_finValid = r_s3Valid;
  assign w_finX     = r_s3X;
  assign w_finY     = r_s3Y;
  assign w_finAbs   = r_s3Abs;

  // Stage 3: square the absolute error so the multiplier is off the accumulate path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3Valid <= 1'b0;
      r_s3X     <= '0;
      r_s3Y     <= '0;
      r_s3Abs   <= '0;
      r_s3Sq    <= '0;
    end else begin
      r_s3Valid <= r_s2Valid;
      r_s3X     <= r_s2X;
      r_s3Y     <= r_s2Y;
      r_s3Abs   <= r_s2Abs;
      r_s3Sq    <= {16'd0, r_s2Abs} * {16'd0, r_s2Abs};
    end
  end

  // Squared-error accumulator, cleared together with the other results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sq_err <= '0;
    end else if (w_startRun) begin
      sum_sq_err <= '0;
    end else if (w_finValid) begin
      sum_sq_err <= sum_sq_err + {{(CNT_W-1){1'b0}}, r_s3Sq};
    end
  end
`else
  // The run may only finish once no sample is still travelling towards the accumulators
  assign w_pipeBusy = r_s1Valid;
  assign w_finValid = r_s2Valid;
  assign w_finX     = r_s2X;
  assign w_finY     = r_s2Y;
  assign w_finAbs   = r_s2Abs;
`endif

  assign w_runDone = (r_state == ST_RUN) && (r_acceptCnt == r_nLat) && !w_pipeBusy;

  // Run control: IDLE/DONE wait for start, RUN ends when all samples are accounted for
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start) r_state <= ST_RUN;
        ST_RUN:           if (w_runDone) r_state <= ST_DONE;
        default:          r_state <= ST_IDLE;
      endcase
    end
  end

  // Run length is latched at start; the accept counter gates in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nLat      <= '0;
      r_acceptCnt <= '0;
    end else if (w_startRun) begin
      r_nLat      <= n_samples;
      r_acceptCnt <= '0;
    end else if (w_take) begin
      r_acceptCnt <= r_acceptCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Stage 1: register the accepted sample and its exact product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1X     <= '0;
      r_s1Y     <= '0;
      r_s1Z     <= '0;
      r_s1Exact <= '0;
    end else begin
      r_s1Valid <= w_take;
      if (w_take) begin
        r_s1X     <= x;
        r_s1Y     <= y;
        r_s1Z     <= z_apx;
        r_s1Exact <= {8'd0, x} * {8'd0, y};
      end
    end
  end

  // Stage 2: register the absolute error and the operands that produced it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2X     <= '0;
      r_s2Y     <= '0;
      r_s2Abs   <= '0;
    end else begin
      r_s2Valid <= r_s1Valid;
      r_s2X     <= r_s1X;
      r_s2Y     <= r_s1Y;
      r_s2Abs   <= w_abs;
    end
  end

  // Result accumulators; a strictly larger error is needed to replace the maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_x       <= '0;
      max_y       <= '0;
    end else if (w_startRun) begin
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_x       <= '0;
      max_y       <= '0;
    end else if (w_finValid) begin
      if (w_finAbs != 16'd0) begin
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      sum_abs_err <= sum_abs_err + {{(SUM_W-16){1'b0}}, w_finAbs};
      if (w_finAbs > max_abs_err) begin
        max_abs_err <= w_finAbs;
        max_x       <= w_finX;
        max_y       <= w_finY;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// tb_approx_mul_err_monitor
// Directed and randomized runs of approx_mul_err_monitor checked against a
// plain-arithmetic model of the run statistics. Honours MON_SQERR_EN.
module tb_approx_mul_err_monitor;

  localparam int CNT_W = 17;
  localparam int SUM_W = 32;
`ifdef MON_SQERR_EN
  localparam int DONE_EDGES = 3;
`else
  localparam int DONE_EDGES = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_samples = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       x = '0;
  logic [7:0]       y = '0;
  logic [15:0]      z_apx = '0;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_cnt;
  logic [SUM_W-1:0] sum_abs_err;
  logic [15:0]      max_abs_err;
  logic [7:0]       max_x;
  logic [7:0]       max_y;
`ifdef MON_SQERR_EN
  logic [47:0]      sum_sq_err;
`endif

  approx_mul_err_monitor #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .n_samples   (n_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .z_apx       (z_apx),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .max_x       (max_x),
`ifdef MON_SQERR_EN
    .sum_sq_err  (sum_sq_err),
`endif
    .max_y       (max_y)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  int edgeCnt     = 0;
  int doneRiseEdge = -1;
  logic prevDone  = 1'b0;

  int sx [64];
  int sy [64];
  int sz [64];
  int ax [$];
  int ay [$];
  int az [$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and observe #1 after the edge; tracks the edge on which done rose
  task automatic step();
    @(posedge clk);
    #1;
    edgeCnt++;
    if (done === 1'b1 && prevDone !== 1'b1) doneRiseEdge = edgeCnt;
    prevDone = done;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".inReady"}, 64'(in_ready), 64'd0);
    checkOutput({tag, ".busy"},    64'(busy),     64'd0);
    checkOutput({tag, ".done"},    64'(done),     64'd0);
    checkOutput({tag, ".errCnt"},  64'(err_cnt),  64'd0);
    checkOutput({tag, ".sumAbs"},  64'(sum_abs_err), 64'd0);
    checkOutput({tag, ".maxAbs"},  64'(max_abs_err), 64'd0);
    checkOutput({tag, ".maxX"},    64'(max_x), 64'd0);
    checkOutput({tag, ".maxY"},    64'(max_y), 64'd0);
`ifdef MON_SQERR_EN
    checkOutput({tag, ".sumSq"},   64'(sum_sq_err), 64'd0);
`endif
  endtask

  // Reference statistics recomputed from the list of accepted samples
  task automatic checkResults(input string tag);
    int eCnt;
    longint sum;
    longint sq;
    int mx;
    int bx;
    int by;
    int d;
    eCnt = 0; sum = 0; sq = 0; mx = 0; bx = 0; by = 0;
    foreach (ax[i]) begin
      d = az[i] - ax[i] * ay[i];
      if (d < 0) d = -d;
      if (d != 0) eCnt++;
      sum += d;
      sq  += longint'(d) * longint'(d);
      if (d > mx) begin
        mx = d; bx = ax[i]; by = ay[i];
      end
    end
    checkOutput({tag, ".errCnt"}, 64'(err_cnt), 64'(eCnt));
    checkOutput({tag, ".sumAbs"}, 64'(sum_abs_err), 64'(sum));
    checkOutput({tag, ".maxAbs"}, 64'(max_abs_err), 64'(mx));
    checkOutput({tag, ".maxX"},   64'(max_x), 64'(bx));
    checkOutput({tag, ".maxY"},   64'(max_y), 64'(by));
`ifdef MON_SQERR_EN
    checkOutput({tag, ".sumSq"},  64'(sum_sq_err), 64'(sq));
`endif
  endtask

  // One complete run: start, offer samples (gapMode 0 none, 1 alternate, 2 random), await done
  task automatic applyStimulus(input int n, input int offered, input int gapMode, input string tag);
    int idx;
    int acc;
    int guard;
    int startEdge;
    int lastAcceptEdge;
    int expDoneEdge;
    bit v;
    idx = 0; acc = 0; guard = 0; lastAcceptEdge = -1;
    ax.delete(); ay.delete(); az.delete();
    doneRiseEdge = -1;
    n_samples = CNT_W'(n);
    start = 1'b1;
    startEdge = edgeCnt + 1;
    step();
    start = 1'b0;
    checkOutput({tag, ".busyAtStart"}, 64'(busy), 64'd1);
    checkOutput({tag, ".doneAtStart"}, 64'(done), 64'd0);
    while (idx < offered && guard < 500) begin
      case (gapMode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      x = 8'(sx[idx]);
      y = 8'(sy[idx]);
      z_apx = 16'(sz[idx]);
      checkOutput({tag, ".inReady"}, 64'(in_ready), 64'(acc < n));
      if (v) begin
        if (in_ready === 1'b1) begin
          ax.push_back(sx[idx]); ay.push_back(sy[idx]); az.push_back(sz[idx]);
          acc++;
          lastAcceptEdge = edgeCnt + 1;
        end
        idx++;
      end
      guard++;
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    checkOutput({tag, ".doneReached"}, 64'(done), 64'd1);
    expDoneEdge = (lastAcceptEdge < 0) ? startEdge + 1 : lastAcceptEdge + DONE_EDGES;
    checkOutput({tag, ".doneEdge"}, 64'(doneRiseEdge), 64'(expDoneEdge));
    checkOutput({tag, ".busyInDone"}, 64'(busy), 64'd0);
    checkOutput({tag, ".readyInDone"}, 64'(in_ready), 64'd0);
    checkResults(tag);
    // Results must stay frozen while junk is offered in DONE
    in_valid = 1'b1; x = 8'd7; y = 8'd9; z_apx = 16'd1;
    step();
    step();
    in_valid = 1'b0;
    checkOutput({tag, ".doneHeld"}, 64'(done), 64'd1);
    checkResults({tag, ".frozen"});
  endtask

  task automatic setSample(input int i, input int a, input int b, input int c);
    sx[i] = a; sy[i] = b; sz[i] = c;
  endtask

  initial begin
    int n;
    int p;
    int kind;
    // Reset held for three cycles
    rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    step();
    checkZero("reset");

    applyStimulus(0, 0, 0, "zeroRun");

    setSample(0, 3, 5, 15);
    setSample(1, 255, 255, 65025);
    applyStimulus(2, 2, 0, "exact");

    setSample(0, 255, 255, 65000);
    setSample(1, 16, 16, 300);
    setSample(2, 10, 10, 100);
    applyStimulus(3, 3, 0, "overUnder");
    checkOutput("overUnder.sum69", 64'(sum_abs_err), 64'd69);
`ifdef MON_SQERR_EN
    checkOutput("overUnder.sq2561", 64'(sum_sq_err), 64'd2561);
`endif

    setSample(0, 2, 2, 5);
    setSample(1, 1, 1, 0);
    setSample(2, 9, 9, 0);
    applyStimulus(2, 3, 1, "tieBackpressure");

    setSample(0, 0, 0, 65535);
    setSample(1, 255, 255, 0);
    applyStimulus(2, 2, 0, "extremes");

    // Abort: reset arrives after the first of four samples has been accumulated
    n_samples = CNT_W'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; x = 8'd1; y = 8'd1; z_apx = 16'd9;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    checkOutput("abort.partialSum", 64'(sum_abs_err), 64'd8);
    rst_n = 1'b0;
    #1;
    checkZero("abortAsync");
    step(); step();
    rst_n = 1'b1;
    step();
    checkZero("abortIdle");

    setSample(0, 0, 0, 7);
    applyStimulus(1, 1, 0, "restart");

    // Randomized runs
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < 30; i++) begin
        sx[i] = $urandom_range(0, 255);
        sy[i] = $urandom_range(0, 255);
        kind = $urandom_range(0, 2);
        p = sx[i] * sy[i];
        if (kind == 0) sz[i] = p;
        else if (kind == 1) sz[i] = $urandom_range(0, 65535);
        else begin
          p = p + $urandom_range(0, 600) - 300;
          sz[i] = (p < 0) ? 0 : ((p > 65535) ? 65535 : p);
        end
      end
      applyStimulus(n, n + $urandom_range(0, 3), 2, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
